// File: rtl/popcount_window_stats.sv
// Windowed sum/max/min statistics over WINDOW valid popcount samples, with early flush.
// Optional min tracking is built only when POPCOUNT_STATS_MIN_EN is defined; otherwise min_o is 0.
module popcount_window_stats #(
  parameter  int WIDTH  = 7,
  parameter  int WINDOW = 16,
  localparam int CNT_W  = $clog2(WIDTH) + 1,
  localparam int SUM_W  = $clog2(WIDTH * WINDOW + 1),
  localparam int SMP_W  = $clog2(WINDOW + 1)
) (
  input  logic             clk_i,
  input  logic             srst_i,
  input  logic [CNT_W-1:0] cnt_i,
  input  logic             cnt_val_i,
  input  logic             flush_i,
  output logic [SUM_W-1:0] sum_o,
  output logic [CNT_W-1:0] max_o,
  output logic [CNT_W-1:0] min_o,
  output logic [SMP_W-1:0] samples_o,
  output logic             stats_val_o
);

  // state   | meaning
  // S_EMPTY | no samples accumulated
  // S_ACC   | 1..WINDOW-1 samples accumulated
  typedef enum logic {S_EMPTY, S_ACC} state_t;

  state_t r_state, w_state_nxt;

  logic [SUM_W-1:0] r_acc_sum, w_new_sum, w_fin_sum, r_sum;
  logic [CNT_W-1:0] r_acc_max, w_new_max, w_fin_max, r_max;
  logic [SMP_W-1:0] r_acc_n,   w_new_n,   w_fin_n,   r_samples;
  logic [CNT_W-1:0] w_cnt;
  logic             w_held, w_close, r_stats_val;

  always_comb begin
    w_cnt       = (cnt_i > CNT_W'(WIDTH)) ? CNT_W'(WIDTH) : cnt_i;
    w_held      = (r_state == S_ACC);
    w_new_sum   = SUM_W'(w_cnt);
    w_new_max   = w_cnt;
    w_new_n     = SMP_W'(1);
    if (w_held) begin
      w_new_sum = r_acc_sum + SUM_W'(w_cnt);
      w_new_max = (w_cnt > r_acc_max) ? w_cnt : r_acc_max;
      w_new_n   = r_acc_n + SMP_W'(1);
    end
    w_fin_sum   = cnt_val_i ? w_new_sum : r_acc_sum;
    w_fin_max   = cnt_val_i ? w_new_max : r_acc_max;
    w_fin_n     = cnt_val_i ? w_new_n   : r_acc_n;
    // A flush only closes a window that actually contains a sample.
    w_close     = (cnt_val_i && (w_new_n == SMP_W'(WINDOW))) ||
                  (flush_i && (cnt_val_i || w_held));
    w_state_nxt = r_state;
    if (w_close)        w_state_nxt = S_EMPTY;
    else if (cnt_val_i) w_state_nxt = S_ACC;
  end

  always_ff @(posedge clk_i or posedge srst_i) begin
    if (srst_i) r_state <= S_EMPTY;
    else        r_state <= w_state_nxt;
  end

  always_ff @(posedge clk_i or posedge srst_i) begin
    if (srst_i) begin
      r_acc_sum <= '0;
      r_acc_max <= '0;
      r_acc_n   <= '0;
    end else if (w_close) begin
      r_acc_sum <= '0;
      r_acc_max <= '0;
      r_acc_n   <= '0;
    end else if (cnt_val_i) begin
      r_acc_sum <= w_new_sum;
      r_acc_max <= w_new_max;
      r_acc_n   <= w_new_n;
    end
  end

  always_ff @(posedge clk_i or posedge srst_i) begin
    if (srst_i) begin
      r_stats_val <= 1'b0;
      r_sum       <= '0;
      r_max       <= '0;
      r_samples   <= '0;
    end else begin
      r_stats_val <= w_close;
      if (w_close) begin
        r_sum     <= w_fin_sum;
        r_max     <= w_fin_max;
        r_samples <= w_fin_n;
      end
    end
  end

`ifdef POPCOUNT_STATS_MIN_EN
  logic [CNT_W-1:0] r_acc_min, w_new_min, w_fin_min, r_min;

  always_comb begin
    w_new_min = w_cnt;
    if (w_held && (r_acc_min < w_cnt)) w_new_min = r_acc_min;
    w_fin_min = cnt_val_i ? w_new_min : r_acc_min;
  end

  always_ff @(posedge clk_i or posedge srst_i) begin
    if (srst_i) begin
      r_acc_min <= '0;
      r_min     <= '0;
    end else begin
      if (w_close)        r_acc_min <= '0;
      else if (cnt_val_i) r_acc_min <= w_new_min;
      if (w_close)        r_min     <= w_fin_min;
    end
  end

  assign min_o = r_min;
`else
  assign min_o = '0;
`endif

  assign sum_o       = r_sum;
  assign max_o       = r_max;
  assign samples_o   = r_samples;
  assign stats_val_o = r_stats_val;

endmodule

// File: doc/popcount_window_stats.md
# popcount_window_stats

Windowed statistics stage placed directly downstream of the bit population counter. Consumes one population count per valid cycle and accumulates sum, maximum and (optionally) minimum over a window of WINDOW valid samples. Publishes one result set per window as a single-cycle pulse for software-visible monitoring or a downstream threshold checker. Supports early window closure via a flush input.

## Interface
- WIDTH, 7: data word width of the upstream counter; input counts range 0..WIDTH.
- WINDOW, 16: valid samples per window; legal range 2..1024.
- CNT_W, $clog2(WIDTH)+1 (derived, not overridden): width of count, max and min.
- SUM_W, $clog2(WIDTH*WINDOW+1) (derived): width of sum.
- SMP_W, $clog2(WINDOW+1) (derived): width of samples_o.
- clk_i  in  1  clock; all logic on rising edge.
- srst_i  in  1  reset, asynchronous, active-high.
- cnt_i  in  CNT_W  population count sample.
- cnt_val_i  in  1  cnt_i is valid this cycle.
- flush_i  in  1  close the current window early.
- sum_o  out  SUM_W  sum of samples in the closed window.
- max_o  out  CNT_W  largest sample in the closed window.
- min_o  out  CNT_W  smallest sample in the closed window (see Configuration).
- samples_o  out  SMP_W  number of samples in the closed window.
- stats_val_o  out  1  one-cycle pulse; result outputs are valid.

## Operation
- States: EMPTY (no samples accumulated), ACC (1..WINDOW-1 samples accumulated).
- Internal registers: acc_sum (SUM_W), acc_max, acc_min (CNT_W), acc_n (SMP_W).
- Sample with cnt_i > WIDTH is clamped to WIDTH before use.
- EMPTY + cnt_val_i: acc_sum=cnt, acc_max=acc_min=cnt, acc_n=1, go to ACC.
- ACC + cnt_val_i: acc_sum+=cnt, acc_max=max(acc_max,cnt), acc_min=min(acc_min,cnt), acc_n+=1.
- Window close condition: the accepted sample makes acc_n reach WINDOW, or flush_i=1 while at least one sample is held or accepted this cycle.
- On close: output registers load the final values, including the same-cycle sample. Accumulators clear and the FSM goes to EMPTY. stats_val_o pulses on the next cycle.
- flush_i in EMPTY with cnt_val_i=0: no effect, no pulse.
- flush_i together with cnt_val_i: the sample is included, then the window closes.
- Sum cannot overflow by construction: SUM_W covers WIDTH*WINDOW.
- Output registers hold their values between pulses; they change only on a close.

## Timing
- Reset values: stats_val_o=0, sum_o=0, max_o=0, min_o=0, samples_o=0. FSM resets to EMPTY and all accumulators to 0.
- Latency: stats_val_o rises 1 cycle after the edge that accepts the closing sample or flush.
- Back-to-back operation: a cnt_val_i in the cycle where stats_val_o=1 is sample 1 of the new window. No bubbles and no sample loss at full rate.
- stats_val_o never stays high for 2 consecutive cycles unless two closes occur on consecutive edges, i.e. flush_i with single-sample windows.
- Reset asserted mid-window: the partial window is discarded, no pulse, outputs return to reset values immediately.

## Configuration
- POPCOUNT_STATS_MIN_EN defined: acc_min tracking is built, and min_o reports the window minimum.
- Not defined: no min logic is built, and min_o is tied to 0.

## Test plan
- WIDTH=7, WINDOW=4; samples 3,7,0,5 on consecutive cycles -> one cycle after the 4th sample: stats_val_o=1, sum_o=15, max_o=7, min_o=0, samples_o=4.
- Continuous valid for 8 cycles with samples 1..8 (8 clamped to 7) -> two pulses, 4 cycles apart:
  - first: sum=10, max=4, min=1;
  - second: sum=5+6+7+7=25, max=7, min=5.
- Samples 2,6 then flush_i alone -> pulse with sum_o=8, max_o=6, min_o=2, samples_o=2. A further flush_i in EMPTY produces no pulse.
- flush_i together with sample 4 while EMPTY -> pulse with sum_o=4, samples_o=1, max_o=min_o=4.
- Reset asserted after 3 samples, released, then 4 samples of 1 -> single pulse with sum_o=4, samples_o=4. Outputs read 0 during reset.
- Build without POPCOUNT_STATS_MIN_EN, repeat the first scenario -> min_o=0, all other outputs unchanged.
